// File: rtl/alu_decode.sv
// alu_decode: decodes ALU-class MIPS instructions into a one-hot ALU control and operands,
// held in a one-entry valid/ready output register.
module alu_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] alu_control,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [4:0]  dest,
    output logic        wen,
    output logic        illegal
);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [11:0] ctl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  rd;
    logic        r_type;
    logic        legal;
    logic        shamt_shift;
    logic        unused;

    assign op     = inst[31:26];
    assign fn     = inst[5:0];
    assign r_type = op == 6'h00;
    // The rs register number is consumed upstream; only its value arrives here.
    assign unused = ^inst[25:21];

    always_comb begin
        ctl = '0;
        if (r_type)
            case (fn)
                6'h20, 6'h21: ctl = 12'h800;
                6'h22, 6'h23: ctl = 12'h400;
                6'h2A:        ctl = 12'h200;
                6'h2B:        ctl = 12'h100;
                6'h24:        ctl = 12'h080;
                6'h27:        ctl = 12'h040;
                6'h25:        ctl = 12'h020;
                6'h26:        ctl = 12'h010;
                6'h00, 6'h04: ctl = 12'h008;
                6'h02, 6'h06: ctl = 12'h004;
                6'h03, 6'h07: ctl = 12'h002;
                default:      ctl = '0;
            endcase
        else
            case (op)
                6'h08, 6'h09: ctl = 12'h800;
                6'h0A:        ctl = 12'h200;
                6'h0B:        ctl = 12'h100;
                6'h0C:        ctl = 12'h080;
                6'h0D:        ctl = 12'h020;
                6'h0E:        ctl = 12'h010;
                6'h0F:        ctl = 12'h001;
                default:      ctl = '0;
            endcase
    end

    assign legal       = |ctl;
    assign shamt_shift = r_type && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
    // Illegal encodings fall back to the R-type operand/dest routing.
    assign src1 = (legal && op == 6'h0F) ? '0 : shamt_shift ? {27'b0, inst[10:6]} : rs_value;
    assign src2 = (r_type || !legal) ? rt_value
                : op[2] ? {16'b0, inst[15:0]} : {{16{inst[15]}}, inst[15:0]};
    assign rd   = (r_type || !legal) ? inst[15:11] : inst[20:16];

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            alu_control <= '0;
            alu_src1    <= '0;
            alu_src2    <= '0;
            dest        <= '0;
            wen         <= 1'b0;
            illegal     <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid   <= 1'b1;
            alu_control <= ctl;
            alu_src1    <= src1;
            alu_src2    <= src2;
            dest        <= rd;
            wen         <= legal && rd != 5'd0;
            illegal     <= !legal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_decode.sv
// tb_alu_decode: directed test-plan cases plus randomized traffic against a queue-based reference.
module tb_alu_decode;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] alu_control;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] ctl;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  d;
        logic        w;
        logic        ill;
    } ent_t;

    ent_t q[$];

    alu_decode dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .rs_value(rs_value), .rt_value(rt_value), .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2), .dest(dest),
        .wen(wen), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(logic v, logic [11:0] c, logic [31:0] a, logic [31:0] b,
                              logic [4:0] d, logic w, logic il);
        check("out_valid", 32'(out_valid), 32'(v));
        check("alu_control", 32'(alu_control), 32'(c));
        check("alu_src1", alu_src1, a);
        check("alu_src2", alu_src2, b);
        check("dest", 32'(dest), 32'(d));
        check("wen", 32'(wen), 32'(w));
        check("illegal", 32'(illegal), 32'(il));
    endtask

    task automatic send(logic [31:0] i, logic [31:0] rs, logic [31:0] rt);
        inst = i; rs_value = rs; rt_value = rt; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    // Reference: maps each mnemonic to its control bit position, then builds operands.
    function automatic ent_t model(logic [31:0] i, logic [31:0] rs, logic [31:0] rt);
        ent_t e;
        int k;
        int lk[8] = '{11, 11, 9, 8, 7, 5, 4, 0};
        int op;
        int fn;
        op = int'(i[31:26]);
        fn = int'(i[5:0]);
        k = -1;
        e.s1 = rs;
        e.s2 = rt;
        e.d = i[15:11];
        if (op == 0) begin
            case (fn)
                'h20, 'h21: k = 11;
                'h22, 'h23: k = 10;
                'h2A: k = 9;
                'h2B: k = 8;
                'h24: k = 7;
                'h27: k = 6;
                'h25: k = 5;
                'h26: k = 4;
                'h00, 'h04: k = 3;
                'h02, 'h06: k = 2;
                'h03, 'h07: k = 1;
                default: k = -1;
            endcase
            if (k >= 1 && k <= 3 && fn < 4) e.s1 = 32'(i[10:6]);
        end else if (op >= 8 && op <= 15) begin
            k = lk[op - 8];
            e.d = i[20:16];
            e.s2 = (op >= 12) ? 32'(i[15:0]) : 32'($signed(i[15:0]));
            if (op == 15) e.s1 = 0;
        end
        e.ill = k < 0;
        e.ctl = e.ill ? 12'd0 : 12'd1 << k;
        e.w = !e.ill && e.d != 0;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] fns[16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h25,
                                6'h26, 6'h27, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07};
        logic [5:0] op;
        logic [5:0] fn;
        int r;
        r = $urandom_range(0, 9);
        op = (r < 5) ? 6'h00 : (r < 9) ? 6'(8 + $urandom_range(0, 7)) : 6'($urandom);
        fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 15)];
        return {op, 20'($urandom), fn};
    endfunction

    initial begin
        logic acc;
        logic drn;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        inst = 32'h0; rs_value = 32'h0; rt_value = 32'h0;
        cyc(); cyc();
        expect_out(0, 12'h000, 0, 0, 0, 0, 0);
        reset = 1'b0;

        send(32'h00221821, 32'd5, 32'd7);
        expect_out(1, 12'h800, 32'd5, 32'd7, 5'd3, 1, 0);
        send(32'h2424FFFF, 32'h10, 32'h0);
        expect_out(1, 12'h800, 32'h10, 32'hFFFFFFFF, 5'd4, 1, 0);
        send(32'h3424FFFF, 32'h10, 32'h0);
        expect_out(1, 12'h020, 32'h10, 32'h0000FFFF, 5'd4, 1, 0);
        send(32'h00022900, 32'h99, 32'h3);
        expect_out(1, 12'h008, 32'd4, 32'd3, 5'd5, 1, 0);
        send(32'h3C061234, 32'h55, 32'h0);
        expect_out(1, 12'h001, 32'h0, 32'h00001234, 5'd6, 1, 0);
        send(32'h8C220000, 32'hA, 32'hB);
        expect_out(1, 12'h000, 32'hA, 32'hB, 5'd0, 0, 1);
        send(32'h00220021, 32'd1, 32'd2);
        expect_out(1, 12'h800, 32'd1, 32'd2, 5'd0, 0, 0);
        cyc();
        check("drained", 32'(out_valid), 0);

        // Back-pressure: A accepted, then B waits while the consumer stalls.
        send(32'h00221821, 32'd1, 32'd0);
        out_ready = 1'b0; in_valid = 1'b1; rs_value = 32'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", 32'(in_ready), 0);
            cyc();
            check("stall_valid", 32'(out_valid), 1);
            check("stall_hold_a", alu_src1, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("resume_in_ready", 32'(in_ready), 1);
        cyc();
        check("order_b", alu_src1, 32'd2);
        rs_value = 32'd3;
        cyc();
        check("order_c", alu_src1, 32'd3);
        check("order_c_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        cyc();
        check("order_end", 32'(out_valid), 0);

        // Reset while a stalled entry is held.
        out_ready = 1'b0;
        send(32'h00221821, 32'd9, 32'd8);
        out_ready = 1'b0;
        check("pre_reset_valid", 32'(out_valid), 1);
        reset = 1'b1; in_valid = 1'b1;
        cyc();
        expect_out(0, 12'h000, 0, 0, 0, 0, 0);
        reset = 1'b0;
        send(32'h3C061234, 32'h0, 32'h0);
        expect_out(1, 12'h001, 32'h0, 32'h00001234, 5'd6, 1, 0);
        cyc();

        for (int n = 0; n < 1500; n++) begin
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            inst = rand_inst();
            rs_value = $urandom;
            rt_value = $urandom;
            #1;
            check("in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
            acc = in_valid && (q.size() == 0 || out_ready);
            drn = q.size() != 0 && out_ready;
            @(posedge clk);
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(model(inst, rs_value, rt_value));
            #1;
            check("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0)
                expect_out(1, q[0].ctl, q[0].s1, q[0].s2, q[0].d, q[0].w, q[0].ill);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
